// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into SEG_W-bit
// segments with one register stage each, plus optional signed saturation and status flags.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cb_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG_W;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  if (SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_param_check
    $error("addsub_pipe: WIDTH must be a positive multiple of SEG_W");
  end

  // Per-stage state: operands travel with the partial sum so later stages can finish it.
  logic             v_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sub_q [STAGES];
  logic             sat_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bp_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];

  logic             v_d   [STAGES];
  logic             c_d   [STAGES];
  logic             sub_d [STAGES];
  logic             sat_d [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] bp_d  [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    logic [SEG_W:0] seg;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Bubbles enter as all-zero payload so nothing undefined ever reaches the outputs.
        v_d[k]   = in_valid;
        sub_d[k] = in_valid & sub;
        sat_d[k] = in_valid & sat;
        a_d[k]   = in_valid ? a : '0;
        bp_d[k]  = in_valid ? (sub ? ~b : b) : '0;
        s_d[k]   = '0;
        c_d[k]   = in_valid & sub;
      end else begin
        v_d[k]   = v_q[k-1];
        sub_d[k] = sub_q[k-1];
        sat_d[k] = sat_q[k-1];
        a_d[k]   = a_q[k-1];
        bp_d[k]  = bp_q[k-1];
        s_d[k]   = s_q[k-1];
        c_d[k]   = c_q[k-1];
      end
      seg = {1'b0, a_d[k][k*SEG_W +: SEG_W]} + {1'b0, bp_d[k][k*SEG_W +: SEG_W]}
          + {{SEG_W{1'b0}}, c_d[k]};
      s_d[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
      c_d[k] = seg[SEG_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its
  // predecessor's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stage arrays are a handful of flops, not RAM, so clearing them on
      // reset is cheap and keeps result/cb_out/ovf at zero after reset.
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        sat_q[k] <= 1'b0;
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        s_q[k]   <= '0;
      end
    end else if (en) begin
      v_q   <= v_d;
      c_q   <= c_d;
      sub_q <= sub_d;
      sat_q <= sat_d;
      a_q   <= a_d;
      bp_q  <= bp_d;
      s_q   <= s_d;
    end
  end

  logic a_msb, bp_msb;
  logic [WIDTH-1:0] sum;

  assign sum       = s_q[STAGES-1];
  assign a_msb     = a_q[STAGES-1][WIDTH-1];
  assign bp_msb    = bp_q[STAGES-1][WIDTH-1];
  assign out_valid = v_q[STAGES-1];
  assign ovf       = (a_msb == bp_msb) && (sum[WIDTH-1] != a_msb);
  // Subtraction reports a borrow, which is the inverted carry of a + ~b + 1.
  assign cb_out    = c_q[STAGES-1] ^ sub_q[STAGES-1];
  assign result    = (sat_q[STAGES-1] && ovf) ? (a_msb ? SMIN : SMAX) : sum;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: fixed corner vectors on three pipeline depths, then randomized
// streams with back-pressure scored against an integer-arithmetic reference model.
module tb_addsub_pipe;

  typedef struct {
    logic [15:0] res;
    logic        cb;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sat;
    logic [15:0] res;
    logic        cb;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst, in_valid, sub, sat, out_ready;
  logic [15:0] a, b;

  logic rdy4, ov4, cb4, of4;
  logic rdy1, ov1, cb1, of1;
  logic rdy16, ov16, cb16, of16;
  logic [15:0] res4, res1, res16;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(16), .SEG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b),
    .sub(sub), .sat(sat), .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .cb_out(cb4), .ovf(of4));

  addsub_pipe #(.WIDTH(16), .SEG_W(16)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
    .sub(sub), .sat(sat), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .cb_out(cb1), .ovf(of1));

  addsub_pipe #(.WIDTH(16), .SEG_W(1)) dut_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .a(a), .b(b),
    .sub(sub), .sat(sat), .out_valid(ov16), .out_ready(out_ready),
    .result(res16), .cb_out(cb16), .ovf(of16));

  int n_total = 0;
  int n_pass  = 0;
  int n_out   = 0;
  int n_acc   = 0;
  exp_t q[$];
  logic hold_valid = 1'b0;
  exp_t held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  function automatic exp_t ref_model(input logic [15:0] ia, input logic [15:0] ib,
                                     input logic isub, input logic isat);
    exp_t e;
    int sa, sb, ua, ub, r;
    sa = $signed(ia);
    sb = $signed(ib);
    ua = int'(ia);
    ub = int'(ib);
    r  = isub ? sa - sb : sa + sb;
    e.cb  = isub ? (ua < ub) : (ua + ub > 65535);
    e.ovf = (r > 32767) || (r < -32768);
    if (isat && e.ovf) e.res = (r > 0) ? 16'h7FFF : 16'h8000;
    else               e.res = r[15:0];
    return e;
  endfunction

  // One cycle: drive at negedge, score whatever handshakes at the next posedge.
  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic isub, input logic isat, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; sub = isub; sat = isat; out_ready = ordy;
    #1;
    if (hold_valid) begin
      check("hold_valid", ov4, 1'b1);
      check("hold_result", res4, held.res);
      check("hold_cb", cb4, held.cb);
      check("hold_ovf", of4, held.ovf);
    end
    check("in_ready", rdy4, !ov4 || ordy);
    if (ov4 && ordy) begin
      if (q.size() == 0) check("spurious_out", 1'b1, 1'b0);
      else begin
        e = q.pop_front();
        check("sb_result", res4, e.res);
        check("sb_cb", cb4, e.cb);
        check("sb_ovf", of4, e.ovf);
      end
      n_out++;
    end
    hold_valid = ov4 && !ordy;
    held.res = res4; held.cb = cb4; held.ovf = of4;
    if (iv && rdy4) begin
      q.push_back(ref_model(ia, ib, isub, isat));
      n_acc++;
    end
  endtask

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l4, l1, l16;
    logic [15:0] r4, r1, r16;
    logic c4, c1, c16, o4, o1, o16;

    vecs[0] = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {ov4, ov1, ov16}, 3'b000);
    check("rst_result", res4, 16'h0000);
    check("rst_flags", {cb4, of4}, 2'b00);
    check("rst_in_ready", rdy4, 1'b1);

    // Corner vectors: one op at a time, latency measured on all three depths.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; sat = vecs[i].sat;
      out_ready = 1'b1;
      l4 = 0; l1 = 0; l16 = 0;
      r4 = '0; r1 = '0; r16 = '0;
      {c4, c1, c16, o4, o1, o16} = '0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (ov4 && l4 == 0)   begin l4 = n;  r4 = res4;   c4 = cb4;   o4 = of4;   end
        if (ov1 && l1 == 0)   begin l1 = n;  r1 = res1;   c1 = cb1;   o1 = of1;   end
        if (ov16 && l16 == 0) begin l16 = n; r16 = res16; c16 = cb16; o16 = of16; end
      end
      check($sformatf("v%0d_lat4", i), l4, 4);
      check($sformatf("v%0d_lat1", i), l1, 1);
      check($sformatf("v%0d_lat16", i), l16, 16);
      check($sformatf("v%0d_res4", i), {r4, c4, o4}, {vecs[i].res, vecs[i].cb, vecs[i].ovf});
      check($sformatf("v%0d_res1", i), {r1, c1, o1}, {vecs[i].res, vecs[i].cb, vecs[i].ovf});
      check($sformatf("v%0d_res16", i), {r16, c16, o16}, {vecs[i].res, vecs[i].cb, vecs[i].ovf});
    end

    // Back-to-back stream: after the 4-cycle fill, one result per cycle.
    n_out = 0; n_acc = 0;
    for (int i = 0; i < 100; i++)
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    check("b2b_accepted", n_acc, 100);
    check("b2b_outputs", n_out, 96);
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("b2b_drained", n_out, 100);
    check("b2b_queue", q.size(), 0);

    // Random valid/ready toggling with stability checks under back-pressure.
    n_out = 0; n_acc = 0;
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           ($urandom % 3) != 0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("rnd_counts", n_out, n_acc);
    check("rnd_queue", q.size(), 0);

    // Reset mid-stream with three ops in flight: nothing stale may ever emerge.
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", {ov4, ov1, ov16}, 3'b000);
    check("mid_rst_result", {res4, cb4, of4}, 18'h0);
    q.delete();
    hold_valid = 1'b0;
    rst = 1'b0; in_valid = 1'b0;
    n_out = 0;
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_no_stale", n_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
